// File: rtl/temp_mon_multi.sv
// Multi-channel ring-oscillator temperature monitor: round-robin scan, windowed edge
// counting averaged over 2^AVG_LOG2 windows, per-channel hysteresis warnings, result stream.
module temp_mon_multi #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 16,
  parameter int AVG_LOG2   = 2,
  parameter int WIN_CYC    = 1000,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_CH-1:0]  osc_in,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_ch,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [2:0]       sample_ch,
  output logic [CNT_W-1:0] sample_data,
  output logic [N_CH-1:0]  warn,
  output logic             overrun,
  output logic             busy
);

  localparam int ACC_W   = CNT_W + AVG_LOG2;
  localparam int IDX_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX);

  localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'(WIN_CYC - 1);
  localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       CH_LAST  = 3'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, UPDATE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ch_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [N_CH-1:0]    osc_s1, osc_s2;
  logic               osc_d3;
  logic [CNT_W-1:0]   hi_thr [N_CH];
  logic [CNT_W-1:0]   lo_thr [N_CH];

  logic               osc_sel;
  logic               osc_rise;
  logic [CNT_W-1:0]   hi_cur, lo_cur;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   avg;
  logic               settle_end, win_end, last_win;
  logic               do_update;
  logic               handshake;

  // Every channel is synchronised; the third flop follows whichever channel is selected.
  // NOTE: clocked blocks use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_s1 <= '0;
      osc_s2 <= '0;
      osc_d3 <= 1'b0;
    end else begin
      osc_s1 <= osc_in;
      osc_s2 <= osc_s1;
      osc_d3 <= osc_sel;
    end
  end

  // NOTE: defaults come first so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    osc_sel = 1'b0;
    hi_cur  = '0;
    lo_cur  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == 3'(i)) begin
        osc_sel = osc_s2[i];
        hi_cur  = hi_thr[i];
        lo_cur  = lo_thr[i];
      end
    end
  end

  assign osc_rise   = osc_sel & ~osc_d3;
  assign cnt_inc    = (osc_rise && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  assign avg        = CNT_W'(acc_q >> AVG_LOG2);
  assign settle_end = (cyc_q == SET_LAST);
  assign win_end    = (cyc_q == WIN_LAST);
  assign last_win   = (idx_q == IDX_LAST);
  assign do_update  = en && (state_q == UPDATE);
  assign handshake  = sample_valid && sample_ready;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SETTLE;
        SETTLE:  if (settle_end) state_d = COUNT;
        COUNT:   if (win_end && last_win) state_d = UPDATE;
        UPDATE:  state_d = SETTLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Scan datapath; dropping en discards the partial window but keeps the channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q  <= '0;
      cyc_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else if (!en) begin
      cyc_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      unique case (state_q)
        SETTLE: begin
          cyc_q <= settle_end ? '0 : cyc_q + 1'b1;
        end
        COUNT: begin
          if (win_end) begin
            cyc_q <= '0;
            cnt_q <= '0;
            acc_q <= acc_q + ACC_W'(cnt_inc);
            if (!last_win) idx_q <= idx_q + 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          cyc_q <= '0;
          idx_q <= '0;
          cnt_q <= '0;
          acc_q <= '0;
        end
      endcase
      if (do_update) ch_q <= (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
    end
  end

  // NOTE: thresholds are a small flop array, not a RAM, so they can take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        hi_thr[i] <= '0;
        lo_thr[i] <= '0;
      end
    end else if (cfg_wr) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_ch == 3'(i)) begin
          if (cfg_sel) lo_thr[i] <= cfg_data;
          else         hi_thr[i] <= cfg_data;
        end
      end
    end
  end

  // Clear wins when both limits trip; a same-cycle threshold write lands after this compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn <= '0;
    end else if (do_update) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_q == 3'(i)) begin
          if (avg < lo_cur)      warn[i] <= 1'b0;
          else if (avg > hi_cur) warn[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      overrun      <= 1'b0;
    end else if (do_update) begin
      sample_valid <= 1'b1;
      sample_ch    <= ch_q;
      sample_data  <= avg;
      overrun      <= sample_valid && !sample_ready;
    end else begin
      overrun <= 1'b0;
      if (handshake) sample_valid <= 1'b0;
    end
  end

endmodule

// File: doc/temp_mon_multi.md
Name: temp_mon_multi

Overview:
Parametrised multi-channel successor to the single-oscillator temperature sensor core. It scans N ring-oscillator channels round-robin. For each channel it counts oscillator edges over a fixed clock window, averages 2^AVG_LOG2 windows, and applies a per-channel high/low hysteresis comparison to produce warning flags. Each averaged result is presented on a valid/ready stream for the UART sender. Thresholds are written through a simple configuration port.

Parameters:
N_CH, 2, number of oscillator channels (1..8).
CNT_W, 16, edge-counter, average and threshold width.
AVG_LOG2, 2, log2 of windows averaged per result (0..4).
WIN_CYC, 1000, clk cycles per counting window (>=2).
SETTLE_CYC, 4, clk cycles discarded after a channel switch (>=3).

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
en  in  1  scan enable, level.
osc_in  in  N_CH  raw ring-oscillator outputs, asynchronous to clk.
cfg_wr  in  1  one-cycle threshold write strobe.
cfg_ch  in  3  channel index for write; indices >= N_CH ignored.
cfg_sel  in  1  0 = write high threshold, 1 = write low threshold.
cfg_data  in  CNT_W  threshold value.
sample_valid  out  1  result available.
sample_ready  in  1  consumer accepts when high with sample_valid.
sample_ch  out  3  channel of presented result.
sample_data  out  CNT_W  averaged count.
warn  out  N_CH  per-channel hysteresis warning flags.
overrun  out  1  one-cycle pulse when an unaccepted sample is overwritten.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, channel 0, counters, accumulator, window index and all thresholds cleared; sample_valid 0, sample_ch 0, sample_data 0, warn all 0, overrun 0, busy 0.
- Only the selected channel's oscillator is counted. It is 2-flop synchronised, then rising-edge detected via a third flop. Oscillator input must be slower than clk/2; faster inputs alias, which is accepted.
- FSM:
  - IDLE: on en=1 go to SETTLE.
  - SETTLE: SETTLE_CYC cycles, edges ignored, then COUNT.
  - COUNT: WIN_CYC cycles, each detected edge increments the counter, saturating at 2^CNT_W-1. At window end, add the counter to the accumulator (CNT_W+AVG_LOG2 bits) and clear the counter. If the window index < 2^AVG_LOG2-1, increment the index and stay in COUNT with no settle; otherwise go to UPDATE.
  - UPDATE: 1 cycle. avg = accumulator >> AVG_LOG2, truncated. Apply hysteresis, load the output register, clear the accumulator and index, advance the channel (N_CH-1 wraps to 0), go to SETTLE.
- en=0 in any state: go to IDLE next cycle. Partial counts and accumulator are discarded; warn, thresholds and the pending sample are kept. The next en=1 restarts at the current channel.
- Hysteresis, evaluated only in UPDATE for the scanned channel:
  - avg > high sets warn.
  - avg < low clears warn.
  - Otherwise warn holds.
  - If both conditions are true (low > high), clear wins.
  - Comparisons are unsigned.
- Output stream:
  - The cycle after UPDATE, sample_valid=1 with sample_ch and sample_data stable until the handshake.
  - The transfer occurs on a cycle with sample_valid and sample_ready both 1. sample_valid drops the next cycle unless a new UPDATE coincides.
  - If UPDATE occurs while sample_valid=1 and no handshake happens that cycle, the data is overwritten, valid stays 1, and overrun pulses. An UPDATE in the same cycle as a handshake loads new data with no overrun.
- Config writes take effect the next cycle. A write in the same cycle as UPDATE for the same channel is applied after the comparison, so the old threshold is used.
- Result period per channel = SETTLE_CYC + 2^AVG_LOG2*WIN_CYC + 1 cycles. The first sample_valid rises that many cycles plus 1 after en rises (IDLE exit).

Test Plan:
- N_CH=2, WIN_CYC=100, AVG_LOG2=2: osc_in[0] period 10 clk, osc_in[1] period 20 clk, sample_ready=1 → alternating samples ch0 = 10 (±1), ch1 = 5 (±1). Samples spaced 405 clk apart.
- ch0 high=12, low=8; sweep ch0 from period 10 to 7 to 10 to 14 clk → warn[0] 0, then 1 (avg≈14), stays 1 at 10, clears at ≈7.
- Hold sample_ready=0 across two UPDATEs → one overrun pulse, sample_data holds the newest result, valid stays 1.
- Drop en mid-COUNT for 3 cycles, then re-raise → busy falls next cycle, no sample from the aborted channel. The next sample is a full-length result for the same channel; warn is unchanged.
- Assert rst_n=0 asynchronously mid-window with warn[1]=1 and valid=1 → all outputs 0 immediately, thresholds 0, scan restarts at ch0.
- Drive osc_in at clk/2 with WIN_CYC large enough that the count exceeds 2^CNT_W-1 (reduced CNT_W=8) → count saturates at 255, no wrap. cfg_ch=7 write is ignored.
